// File: rtl/matmul_pkg.sv
// Shared constants and FSM encoding for the matrix-multiply result path.
package matmul_pkg;

    localparam int DATA_W      = 16;
    localparam int NUM_RESULTS = 6;
    localparam int SEL_W       = 3;

    localparam logic [SEL_W-1:0] SEL_IDLE = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STREAM = 2'b01,
        DONE   = 2'b10
    } stream_state_t;

endpackage

// File: rtl/result_buffer.sv
// Result slot register file with per-slot valid flags and a combinational read port.
module result_buffer
    import matmul_pkg::*;
#(
    parameter int DATA_W      = matmul_pkg::DATA_W,
    parameter int NUM_RESULTS = matmul_pkg::NUM_RESULTS,
    parameter int SEL_W       = matmul_pkg::SEL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [SEL_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              full
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_RESULTS - 1);

    logic [DATA_W-1:0]      r_mem [NUM_RESULTS];
    logic [NUM_RESULTS-1:0] r_valid_mask;
    logic                   w_wr_hit;

    assign w_wr_hit = wr_en && (wr_sel <= LAST_SLOT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid_mask <= '0;
        end else if (clr) begin
            r_valid_mask <= '0;
        end else if (w_wr_hit) begin
            r_valid_mask[wr_sel] <= 1'b1;
        end
    end

    // Slot storage carries no reset; the valid mask alone qualifies it.
    always_ff @(posedge clk) begin
        if (w_wr_hit) begin
            r_mem[wr_sel] <= wr_data;
        end
    end

    assign rd_data = (rd_addr <= LAST_SLOT) ? r_mem[rd_addr] : '0;
    assign full    = &r_valid_mask;

endmodule

// File: rtl/result_streamer.sv
// Captures demuxed MAC results into slots and streams them in slot order over valid/ready.
module result_streamer
    import matmul_pkg::*;
#(
    parameter int DATA_W      = matmul_pkg::DATA_W,
    parameter int NUM_RESULTS = matmul_pkg::NUM_RESULTS,
    parameter int SEL_W       = matmul_pkg::SEL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_clr,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_RESULTS - 1);

    stream_state_t     r_state;
    stream_state_t     w_state_nxt;
    logic [SEL_W-1:0]  r_rd_ptr;
    logic [SEL_W-1:0]  w_rd_ptr_nxt;
    logic [SEL_W-1:0]  w_ptr_inc;
    logic [DATA_W-1:0] r_dout;
    logic [DATA_W-1:0] w_dout_nxt;
    logic              r_dout_valid;
    logic              w_dout_valid_nxt;
    logic              r_dout_last;
    logic              w_dout_last_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_err;
    logic              w_err_nxt;

    logic              w_slot_wr;
    logic              w_wr_en;
    logic              w_buf_clr;
    logic [SEL_W-1:0]  w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_full;

    result_buffer #(
        .DATA_W      (DATA_W),
        .NUM_RESULTS (NUM_RESULTS),
        .SEL_W       (SEL_W)
    ) u_result_buffer (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_buf_clr),
        .wr_en   (w_wr_en),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data),
        .full    (w_full)
    );

    assign w_slot_wr = (wr_sel <= LAST_SLOT);
    assign w_ptr_inc = r_rd_ptr + 1'b1;

    always_comb begin
        w_state_nxt      = r_state;
        w_rd_ptr_nxt     = r_rd_ptr;
        w_dout_nxt       = r_dout;
        w_dout_valid_nxt = r_dout_valid;
        w_dout_last_nxt  = r_dout_last;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_err_nxt        = r_err;
        w_wr_en          = 1'b0;
        w_buf_clr        = 1'b0;
        w_rd_addr        = '0;

        if (mem_clr) begin
            w_state_nxt      = IDLE;
            w_rd_ptr_nxt     = '0;
            w_dout_valid_nxt = 1'b0;
            w_dout_last_nxt  = 1'b0;
            w_busy_nxt       = 1'b0;
            w_err_nxt        = 1'b0;
            w_buf_clr        = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_wr_en = w_slot_wr;
                    // w_full reflects the mask before this edge's write.
                    if (start) begin
                        if (w_full) begin
                            w_state_nxt      = STREAM;
                            w_rd_ptr_nxt     = '0;
                            w_dout_nxt       = w_rd_data;
                            w_dout_valid_nxt = 1'b1;
                            w_dout_last_nxt  = (LAST_SLOT == '0);
                            w_busy_nxt       = 1'b1;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                STREAM: begin
                    w_rd_addr = w_ptr_inc;
                    if (w_slot_wr) begin
                        w_err_nxt = 1'b1;
                    end
                    if (r_dout_valid && dout_ready) begin
                        if (r_rd_ptr == LAST_SLOT) begin
                            w_state_nxt      = DONE;
                            w_dout_valid_nxt = 1'b0;
                            w_dout_last_nxt  = 1'b0;
                            w_busy_nxt       = 1'b0;
                            w_done_nxt       = 1'b1;
                        end else begin
                            w_rd_ptr_nxt    = w_ptr_inc;
                            w_dout_nxt      = w_rd_data;
                            w_dout_last_nxt = (w_ptr_inc == LAST_SLOT);
                        end
                    end
                end
                DONE: begin
                    w_buf_clr   = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_rd_ptr     <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_dout_last  <= w_dout_last_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_last;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_result_streamer.sv
// Scoreboard bench for result_streamer: fill, stream, backpressure, errors, clear and reset.
module tb_result_streamer;
    import matmul_pkg::*;

    logic              clk;
    logic              reset;
    logic              mem_clr;
    logic [SEL_W-1:0]  wr_sel;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    logic [DATA_W:0] exp_q [$];
    logic [DATA_W:0] sb_e;

    result_streamer dut (
        .clk        (clk),
        .reset      (reset),
        .mem_clr    (mem_clr),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .start      (start),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] word(input int i);
        return DATA_W'(16'h0011 * (i + 1));
    endfunction

    // Consumer side: every accepted word is popped and compared.
    always @(negedge clk) begin
        if (reset && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_word", 32'd1, 32'd0);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_dout", 32'(dout), 32'(sb_e[DATA_W-1:0]));
                chk("sb_last", 32'(dout_last), 32'(sb_e[DATA_W]));
            end
        end
        if (done) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            wr_sel  = SEL_W'(i);
            wr_data = word(i);
            tick();
        end
        wr_sel = SEL_IDLE;
    endtask

    task automatic push_all();
        for (int i = 0; i < NUM_RESULTS; i++)
            exp_q.push_back({(i == NUM_RESULTS - 1), word(i)});
    endtask

    task automatic clear_buf();
        mem_clr = 1'b1;
        tick();
        mem_clr = 1'b0;
    endtask

    task automatic start_expect_err(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_err"}, 32'(err), 32'd1);
        chk({tag, "_valid"}, 32'(dout_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic stream(input int stall_idx, input int stall_n, input bit wr_during);
        int cyc;
        int stalled;
        push_all();
        start      = 1'b1;
        dout_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("first_valid", 32'(dout_valid), 32'd1);
        chk("first_busy", 32'(busy), 32'd1);
        if (wr_during) begin
            wr_sel  = 3'b010;
            wr_data = 16'hBEEF;
            start   = 1'b1;
        end
        cyc     = 0;
        stalled = 0;
        while (!done && cyc < 60) begin
            if (stalled < stall_n && (stalled > 0 || (dout_valid && dout == word(stall_idx)))) begin
                chk("hold_dout", 32'(dout), 32'(word(stall_idx)));
                chk("hold_valid", 32'(dout_valid), 32'd1);
                dout_ready = 1'b0;
                stalled++;
            end else begin
                dout_ready = 1'b1;
            end
            tick();
            cyc++;
            wr_sel = SEL_IDLE;
            start  = 1'b0;
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("stream_cycles", 32'(cyc), 32'(NUM_RESULTS + stall_n));
        chk("end_valid", 32'(dout_valid), 32'd0);
        chk("end_last", 32'(dout_last), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int nd;
        reset      = 1'b0;
        mem_clr    = 1'b0;
        wr_sel     = SEL_IDLE;
        wr_data    = '0;
        start      = 1'b0;
        dout_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_last", 32'(dout_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Fill and stream with no backpressure; mask must be empty afterwards.
        fill(NUM_RESULTS);
        stream(0, 0, 1'b0);
        chk("no_err_clean", 32'(err), 32'd0);
        start_expect_err("mask_cleared");
        clear_buf();
        chk("clr_err", 32'(err), 32'd0);

        // Backpressure on slot 2 for three cycles.
        fill(NUM_RESULTS);
        stream(2, 3, 1'b0);
        chk("bp_err", 32'(err), 32'd0);

        // Incomplete start, then complete and stream; err stays sticky.
        clear_buf();
        fill(NUM_RESULTS - 1);
        start_expect_err("incomplete");
        wr_sel  = 3'd5;
        wr_data = word(5);
        tick();
        wr_sel = SEL_IDLE;
        stream(0, 0, 1'b0);
        chk("sticky_err", 32'(err), 32'd1);

        // Idle codes must not set any slot.
        clear_buf();
        fill(NUM_RESULTS - 1);
        wr_sel  = 3'b110;
        wr_data = 16'hAAAA;
        tick();
        wr_sel = 3'b111;
        tick();
        wr_sel = SEL_IDLE;
        start_expect_err("idle_codes");

        // Write and start during STREAM: write ignored, err set.
        clear_buf();
        fill(NUM_RESULTS);
        stream(0, 0, 1'b1);
        chk("wr_in_stream_err", 32'(err), 32'd1);

        // mem_clr after two words have been accepted.
        clear_buf();
        fill(NUM_RESULTS);
        push_all();
        start      = 1'b1;
        dout_ready = 1'b1;
        tick();
        start   = 1'b0;
        wr_sel  = 3'd3;
        wr_data = 16'h1234;
        tick();
        wr_sel = SEL_IDLE;
        tick();
        chk("pre_clr_err", 32'(err), 32'd1);
        chk("pre_clr_dout", 32'(dout), 32'(word(2)));
        nd         = n_done;
        mem_clr    = 1'b1;
        dout_ready = 1'b0;
        tick();
        mem_clr = 1'b0;
        chk("clr_valid", 32'(dout_valid), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_err_mid", 32'(err), 32'd0);
        chk("clr_last", 32'(dout_last), 32'd0);
        chk("clr_left", 32'(exp_q.size()), 32'd4);
        exp_q.delete();
        tick();
        tick();
        tick();
        chk("clr_no_done", 32'(n_done), 32'(nd));
        start_expect_err("clr_mask");

        // Reset for one cycle in the middle of a stream.
        clear_buf();
        fill(NUM_RESULTS);
        push_all();
        start      = 1'b1;
        dout_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dout_ready = 1'b0;
        reset      = 1'b0;
        tick();
        reset = 1'b1;
        exp_q.delete();
        chk("mrst_dout", 32'(dout), 32'd0);
        chk("mrst_valid", 32'(dout_valid), 32'd0);
        chk("mrst_last", 32'(dout_last), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        start_expect_err("mrst_start");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/result_streamer.md
Name: result_streamer

Overview:
Downstream stage of the matrix-multiply controller datapath. It captures the 16-bit MAC results as they are demuxed out, one slot per `wr_sel` code. On `start`, it streams the results in slot order over a valid/ready output port. It replaces the ad-hoc "dout" phase that follows the final controller state.

Parameters:
DATA_W, 16, width of each result word and of dout
NUM_RESULTS, 6, number of result slots (slot indices 0..NUM_RESULTS-1)
SEL_W, 3, width of wr_sel; all-ones code (3'b111) means no write

Ports:
clk  input  1  clock, all state updated on posedge
reset  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
mem_clr  input  1  clear all slot-valid flags and abort any stream
wr_sel  input  SEL_W  slot index for capture; codes >= NUM_RESULTS = idle
wr_data  input  DATA_W  result word captured when wr_sel is a valid index
start  input  1  request to stream the buffered results
dout  output  DATA_W  current output word
dout_valid  output  1  dout holds a valid word
dout_ready  input  1  consumer accepts dout this cycle
dout_last  output  1  high with the final word (slot NUM_RESULTS-1)
busy  output  1  high in STREAM
done  output  1  one-cycle pulse after the final handshake
err  output  1  sticky protocol error flag

Behaviour:
- Priority each posedge: reset low > mem_clr > normal operation.
- Reset values:
  - state = IDLE; valid_mask = 0; rd_ptr = 0.
  - dout = 0; dout_valid = 0; dout_last = 0; busy = 0; done = 0; err = 0.
  - Slot data registers are not reset.
- mem_clr in any state:
  - valid_mask = 0, err = 0, state = IDLE, rd_ptr = 0.
  - dout_valid = 0, dout_last = 0, busy = 0, done = 0.
  - A write in the same cycle is dropped.
- States: IDLE, STREAM, DONE. All outputs are registered.
- IDLE:
  - wr_sel < NUM_RESULTS: mem[wr_sel] <= wr_data and valid_mask[wr_sel] <= 1.
  - Rewriting a slot overwrites it; no error.
  - start with valid_mask all ones (as registered before this edge): go to STREAM, rd_ptr = 0. Next cycle dout = mem[0], dout_valid = 1, busy = 1.
  - A write landing in the same cycle as start is performed, but start evaluates the pre-write mask.
  - start with an incomplete mask: err <= 1, stay in IDLE.
- STREAM:
  - dout and dout_last are held stable while dout_valid && !dout_ready.
  - On dout_valid && dout_ready with rd_ptr < NUM_RESULTS-1: rd_ptr++, and dout = mem[rd_ptr+1] the next cycle. This gives zero-bubble back-to-back transfers.
  - dout_last = (rd_ptr == NUM_RESULTS-1).
  - Handshake on the last word: dout_valid = 0, dout_last = 0, busy = 0, go to DONE.
  - Any write (wr_sel valid index) in STREAM is ignored and sets err. start in STREAM is ignored, no error.
- DONE: done = 1 for exactly this one cycle; valid_mask <= 0; return to IDLE.
- err stays at 1 until reset or mem_clr.
- Latency:
  - start edge to first dout_valid: 1 cycle.
  - Minimum full stream: NUM_RESULTS cycles with dout_ready held high.
  - Final handshake to done pulse: 1 cycle.
- Interaction with the controller: the controller drives wr_sel on negedge, so this block has half a cycle of setup before the posedge sample.

Decomposition:
- Shared package matmul_pkg:
  - constants DATA_W, NUM_RESULTS, SEL_W;
  - SEL_IDLE = 3'b111;
  - state encoding IDLE = 2'b00, STREAM = 2'b01, DONE = 2'b10.
- One sub-module, result_buffer:
  - NUM_RESULTS x DATA_W register file with a valid_mask;
  - write port (sel/data/enable) and combinational read port (addr).
  - The FSM, rd_ptr and output registers remain in result_streamer.

Test Plan:
- Reset mid-stream: reset low for one cycle during STREAM -> next cycle all outputs 0 and state IDLE. A following start without fresh writes sets err = 1.
- Fill and stream, no backpressure: write slots 0..5 with 0x0011, 0x0022, …, 0x0066, then start with dout_ready = 1. Required response: dout_valid on 6 consecutive cycles carrying 0x0011..0x0066, dout_last only on 0x0066, done pulses on the following cycle, valid_mask returns to 0.
- Backpressure: same fill, dout_ready low for 3 cycles while 0x0033 is presented -> dout holds 0x0033 with dout_valid = 1 throughout; order and count are unchanged afterwards.
- Incomplete start: write slots 0..4 only, then start -> err = 1, dout_valid stays 0. Write slot 5 = 0x0066, then start -> streaming proceeds normally; err stays 1.
- Idle codes and writes during STREAM: wr_sel = 3'b110 and 3'b111 in IDLE -> no mask change. wr_sel = 3'b010 during STREAM -> err = 1 and the streamed slot 2 value is unchanged.
- mem_clr during STREAM after 2 words -> next cycle dout_valid = 0, busy = 0, err = 0, valid_mask = 0, and no done pulse.
